// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle: hazard/redirect requests in, PC-update and flush controls out.
// The sequencer takes the master view and the pipeline side takes the slave view.
interface fetch_sequencer_if;
  logic        ExceptionReq;
  logic [31:0] ExceptionPC;
  logic        Eret;
  logic        JumpValid;
  logic        BranchTaken;
  logic        LoadUseHazard;
  logic [1:0]  PCSrc;
  logic        PCWrite;
  logic        ChooseEPC;
  logic [31:0] ExceptionResumeAddr;
  logic        FlushIFID;
  logic        FlushIDEX;
  logic [31:0] EPC;
  logic        InException;
  logic        DoubleFault;

  modport master (
    input  ExceptionReq, ExceptionPC, Eret, JumpValid, BranchTaken, LoadUseHazard,
    output PCSrc, PCWrite, ChooseEPC, ExceptionResumeAddr, FlushIFID, FlushIDEX,
           EPC, InException, DoubleFault
  );

  modport slave (
    output ExceptionReq, ExceptionPC, Eret, JumpValid, BranchTaken, LoadUseHazard,
    input  PCSrc, PCWrite, ChooseEPC, ExceptionResumeAddr, FlushIFID, FlushIDEX,
           EPC, InException, DoubleFault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC/flush sequencer: fixed-priority arbitration of exceptions, ERET,
// redirects and load-use stalls, with a multi-cycle exception drain and the EPC register.
module fetch_sequencer #(
  parameter int unsigned EXC_DRAIN_CYCLES = 2,
  parameter logic [31:0] HANDLER_ADDR     = 32'h0000_0180
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    RUN,
    EXC_DRAIN,
    EXC_REDIRECT,
    ERET_REDIRECT
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(EXC_DRAIN_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] epc_reg, epc_next;
  logic        in_exc_reg, in_exc_next;
  logic        dfault_reg, dfault_next;

  logic [1:0]  pcsrc;
  logic        pcwrite;
  logic        choose_epc;
  logic        flush_ifid;
  logic        flush_idex;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      cnt_reg    <= 4'd0;
      epc_reg    <= 32'd0;
      in_exc_reg <= 1'b0;
      dfault_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      epc_reg    <= epc_next;
      in_exc_reg <= in_exc_next;
      dfault_reg <= dfault_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    epc_next    = epc_reg;
    in_exc_next = in_exc_reg;
    dfault_next = dfault_reg;
    pcsrc       = 2'b00;
    pcwrite     = 1'b0;
    choose_epc  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (bus.ExceptionReq && !in_exc_reg) begin
          epc_next   = bus.ExceptionPC;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          cnt_next   = DRAIN_LOAD;
          state_next = EXC_DRAIN;
        end else begin
          // A nested exception only marks the double fault; the lower-priority
          // rules still decide this cycle's fetch behaviour.
          if (bus.ExceptionReq) begin
            dfault_next = 1'b1;
          end
          if (bus.Eret && in_exc_reg) begin
            flush_ifid = 1'b1;
            state_next = ERET_REDIRECT;
          end else if (bus.JumpValid || bus.BranchTaken) begin
            pcsrc      = {bus.JumpValid, bus.BranchTaken & ~bus.JumpValid};
            pcwrite    = 1'b1;
            flush_ifid = 1'b1;
          end else if (bus.LoadUseHazard) begin
            flush_idex = 1'b1;
          end else begin
            pcwrite = 1'b1;
          end
        end
      end

      EXC_DRAIN: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (cnt_reg == 4'd0) begin
          state_next = EXC_REDIRECT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      EXC_REDIRECT: begin
        choose_epc  = 1'b1;
        pcwrite     = 1'b1;
        flush_ifid  = 1'b1;
        in_exc_next = 1'b1;
        state_next  = RUN;
      end

      ERET_REDIRECT: begin
        choose_epc  = 1'b1;
        pcwrite     = 1'b1;
        flush_ifid  = 1'b1;
        in_exc_next = 1'b0;
        state_next  = RUN;
      end

      default: begin
        state_next = RUN;
      end
    endcase

    // Reset holds every fetch control inactive so nothing leaks into the pipeline.
    if (reset) begin
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      choose_epc = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      state_next = RUN;
    end
  end

  assign bus.PCSrc               = pcsrc;
  assign bus.PCWrite             = pcwrite;
  assign bus.ChooseEPC           = choose_epc;
  assign bus.FlushIFID           = flush_ifid;
  assign bus.FlushIDEX           = flush_idex;
  assign bus.ExceptionResumeAddr = (state_reg == ERET_REDIRECT) ? epc_reg : HANDLER_ADDR;
  assign bus.EPC                 = epc_reg;
  assign bus.InException         = in_exc_reg;
  assign bus.DoubleFault         = dfault_reg;

endmodule
